uart_buffer: RTL and testbench
==============================

# uart_buffer

Byte-level buffering stage that sits directly upstream of the AXI-Lite UART driver and directly downstream of the core's I/O port. It holds outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO. It issues one request at a time to the driver's `t_valid`/`r_valid` interface and retires each request on the driver's `tx_done`/`rx_done` pulse. The core sees plain valid/ready byte streams and never stalls on the serial link unless a FIFO is full or empty.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, 2..256.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `tx_valid` in 1: core offers `tx_byte`.
- `tx_ready` out 1: TX FIFO not full.
- `tx_byte` in 8: byte to transmit.
- `rx_valid` out 1: RX FIFO not empty; `rx_byte` valid.
- `rx_ready` in 1: core pops the RX head.
- `rx_byte` out 8: RX FIFO head (first-word-fall-through).
- `rx_want` in 1: level; the core is waiting for input, which permits RX requests.
- `t_valid` out 1: TX request pulse to the driver.
- `t_data` out 8: byte for the driver; held stable from request until `tx_done`.
- `r_valid` out 1: RX request pulse to the driver.
- `r_data` in 8: received byte; valid in the `rx_done` cycle.
- `tx_done` in 1: driver TX completion pulse.
- `rx_done` in 1: driver RX completion pulse.
- `tx_count` out 32: bytes sent (see Configuration).
- `rx_count` out 32: bytes received (see Configuration).

## Operation
- FIFOs use `log2(DEPTH)+1`-bit read and write pointers.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2·DEPTH.
- TX push occurs when `tx_valid && tx_ready`. RX pop occurs when `rx_valid && rx_ready`. Pops from an empty RX FIFO are ignored.
- Scheduler FSM states are IDLE, TX_REQ, TX_WAIT, RX_REQ, RX_WAIT.
  - IDLE: if the TX FIFO is not empty, go to TX_REQ. Otherwise, if `rx_want` is set and the RX FIFO is not full, go to RX_REQ. Otherwise stay in IDLE. TX has strict priority.
  - TX_REQ: `t_valid`=1 for exactly one cycle, `t_data`=TX head; then go to TX_WAIT.
  - TX_WAIT: `t_valid`=0, `t_data` holds. On `tx_done`, pop the TX head and go to IDLE.
  - RX_REQ: `r_valid`=1 for exactly one cycle; then go to RX_WAIT.
  - RX_WAIT: `r_valid`=0. On `rx_done`, push `r_data` into the RX FIFO and go to IDLE. Space is guaranteed because the FIFO was checked non-full in IDLE and the scheduler is the only RX writer.
- Once issued, an RX request waits until a byte arrives, even if `rx_want` drops. TX bytes pushed meanwhile stay queued.
- `tx_done` outside TX_WAIT and `rx_done` outside RX_WAIT are ignored.
- A core push to the TX FIFO in the same cycle as a scheduler pop is allowed; occupancy is unchanged. The same holds for an RX push and a core pop in the same cycle.

## Timing
- Reset values:
  - FSM state is IDLE and both FIFOs are empty.
  - `tx_ready`=1, `rx_valid`=0, `rx_byte`=0.
  - `t_valid`=0, `r_valid`=0, `t_data`=0.
  - `tx_count`=0, `rx_count`=0.
- All outputs are registered, except `tx_ready`, `rx_valid` and `rx_byte`, which are decoded from the FIFO pointers and RAM.
- Push into an empty TX FIFO at cycle N: IDLE sees non-empty at N+1, and `t_valid`=1 at N+2.
- `tx_done` at cycle M: the TX pop happens at M+1, IDLE is reached at M+1, and the next `t_valid` is at M+2 at the earliest. This gives at least one idle cycle at the driver between requests.
- `rx_done` at cycle M: `rx_valid`=1 at M+1 with `rx_byte`=`r_data`.
- `t_valid` and `r_valid` are never both high, and never high for two consecutive cycles.
- `rstn` low mid-request: the FSM and FIFOs return to reset within one cycle and any queued bytes are discarded. The driver shares `rstn`, so there is no orphaned handshake.

## Configuration
- `UART_BUF_STATS_EN` defined:
  - `tx_count` increments on each accepted `tx_done`.
  - `rx_count` increments on each accepted `rx_done`.
  - Both counters wrap 0xFFFFFFFF→0.
- Not defined: `tx_count` and `rx_count` are constant 0 and no counter flops are synthesized.

## Test plan
- After reset, push 0x41: `t_valid` pulses 2 cycles later with `t_data`=0x41. Hold `tx_done` off 20 cycles: `t_data` stays 0x41 and no second pulse occurs. Pulse `tx_done`: the FIFO becomes empty.
- With `DEPTH`=16, push 17 bytes with the driver stalled: `tx_ready`=0 after the 16th byte. The 17th byte is accepted only after the first `tx_done`. All bytes come out in order, and `tx_count`=17 when stats are enabled.
- `rx_want`=1 with an empty TX FIFO: `r_valid` pulses once. `rx_done` with `r_data`=0x5A: `rx_valid`=1 next cycle with `rx_byte`=0x5A. Pop it: `rx_valid`=0.
- TX byte queued while `rx_want`=1: the `t_valid` request is issued before any `r_valid`. During RX_WAIT, a new TX push is not issued until `rx_done`.
- Fill the RX FIFO to 16 with `rx_want` held: no further `r_valid` is issued. After one pop, exactly one new `r_valid` is issued.
- Assert `rstn`=0 during TX_WAIT with 3 bytes queued: next cycle `tx_ready`=1, `t_valid`=0, the FIFOs are empty and the counters are 0.

Source files
------------

// File: rtl/uart_buffer_if.sv
// Core-side byte streams and driver-side request/completion signals of the UART buffer.
// master: core plus driver; slave: the buffer itself.
interface uart_buffer_if;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_byte;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  rx_byte;
   logic        rx_want;
   logic        t_valid;
   logic [7:0]  t_data;
   logic        r_valid;
   logic [7:0]  r_data;
   logic        tx_done;
   logic        rx_done;
   logic [31:0] tx_count;
   logic [31:0] rx_count;

   modport master (
      output tx_valid, tx_byte, rx_ready, rx_want,
      output r_data, tx_done, rx_done,
      input  tx_ready, rx_valid, rx_byte,
      input  t_valid, t_data, r_valid,
      input  tx_count, rx_count
   );

   modport slave (
      input  tx_valid, tx_byte, rx_ready, rx_want,
      input  r_data, tx_done, rx_done,
      output tx_ready, rx_valid, rx_byte,
      output t_valid, t_data, r_valid,
      output tx_count, rx_count
   );
endinterface

// File: rtl/uart_buffer.sv
// TX/RX byte FIFOs with a one-request-at-a-time scheduler in front of the UART driver.
// Define UART_BUF_STATS_EN to enable the tx_count/rx_count byte counters.
module uart_buffer #(
   parameter int DEPTH = 16
) (
   input logic         clk,
   input logic         rstn,
   uart_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] INC = (AW+1)'(1);

   typedef enum logic [2:0] {
      IDLE, TX_REQ, TX_WAIT, RX_REQ, RX_WAIT
   } state_t;

   state_t state;

   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [AW:0] tx_wp, tx_rp;
   logic [AW:0] rx_wp, rx_rp;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop;

   assign tx_empty = tx_wp == tx_rp;
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                     (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                     (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

   assign tx_push = bus.tx_valid && !tx_full;
   assign tx_pop  = (state == TX_WAIT) && bus.tx_done;
   assign rx_push = (state == RX_WAIT) && bus.rx_done;
   assign rx_pop  = bus.rx_ready && !rx_empty;

   assign bus.tx_ready = !tx_full;
   assign bus.rx_valid = !rx_empty;
   assign bus.rx_byte  = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.tx_byte;
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= bus.r_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + INC;
         if (tx_pop)  tx_rp <= tx_rp + INC;
         if (rx_push) rx_wp <= rx_wp + INC;
         if (rx_pop)  rx_rp <= rx_rp + INC;
      end
   end

   // TX wins over RX; a request is retired only by its own done pulse
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         bus.t_valid <= 1'b0;
         bus.r_valid <= 1'b0;
         bus.t_data  <= 8'h00;
      end else begin
         bus.t_valid <= 1'b0;
         bus.r_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!tx_empty) begin
                  state       <= TX_REQ;
                  bus.t_valid <= 1'b1;
                  bus.t_data  <= tx_mem[tx_rp[AW-1:0]];
               end else if (bus.rx_want && !rx_full) begin
                  state       <= RX_REQ;
                  bus.r_valid <= 1'b1;
               end
            end
            TX_REQ:  state <= TX_WAIT;
            TX_WAIT: if (bus.tx_done) state <= IDLE;
            RX_REQ:  state <= RX_WAIT;
            RX_WAIT: if (bus.rx_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_BUF_STATS_EN
   logic [31:0] tx_cnt, rx_cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_cnt <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_pop)  tx_cnt <= tx_cnt + 32'd1;
         if (rx_push) rx_cnt <= rx_cnt + 32'd1;
      end
   end

   assign bus.tx_count = tx_cnt;
   assign bus.rx_count = rx_cnt;
`else
   assign bus.tx_count = '0;
   assign bus.rx_count = '0;
`endif
endmodule

// File: tb/tb_uart_buffer.sv
// Randomised bench for uart_buffer: acts as core and driver, checks against a queue model.
// Directed scenarios first, then randomised traffic with occasional resets.
module tb_uart_buffer;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   uart_buffer_if bus();

   uart_buffer #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic [7:0] push_q[$];
   bit tx_busy, rx_busy, exp_tv, exp_rv, post_rst;
   int tx_dly, rx_dly;
   int unsigned m_txc, m_rxc;

   // stimulus knobs and observation counters
   int push_pct, pop_pct, dly_hi;
   bit want, hold_tx, hold_rx, spur, pop_one, rst_req, rdata_fix;
   logic [7:0] rdata_val;
   int cyc, tv_cnt, rv_cnt, tv_cyc, n_acc;

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      push_q.delete();
      tx_busy = 0;
      rx_busy = 0;
      exp_tv = 0;
      exp_rv = 0;
      m_txc = 0;
      m_rxc = 0;
      post_rst = 1;
   endtask

   task automatic step();
      bit tp, rp, idle, acc, pop, tfin, rfin, from_list;
      @(negedge clk);
      cyc++;
      check("t_valid", 32'(bus.t_valid), 32'(exp_tv));
      check("r_valid", 32'(bus.r_valid), 32'(exp_rv));
      check("tx_ready", 32'(bus.tx_ready), 32'(txq.size() < DEPTH));
      check("rx_valid", 32'(bus.rx_valid), 32'(rxq.size() != 0));
      if (rxq.size() != 0) check("rx_byte", 32'(bus.rx_byte), 32'(rxq[0]));
      if (post_rst) begin
         check("rst_t_data", 32'(bus.t_data), 32'h0);
         check("rst_rx_byte", 32'(bus.rx_byte), 32'h0);
         post_rst = 0;
      end
`ifdef UART_BUF_STATS_EN
      check("tx_count", bus.tx_count, m_txc);
      check("rx_count", bus.rx_count, m_rxc);
`else
      check("tx_count", bus.tx_count, 32'h0);
      check("rx_count", bus.rx_count, 32'h0);
`endif
      tv_cnt += int'(bus.t_valid);
      rv_cnt += int'(bus.r_valid);
      if (bus.t_valid) tv_cyc = cyc;

      tp = exp_tv;
      rp = exp_rv;
      if (tp) begin
         tx_busy = 1;
         tx_dly = $urandom_range(dly_hi, 0);
      end
      if (tx_busy && txq.size() != 0)
         check("t_data", 32'(bus.t_data), 32'(txq[0]));
      if (rp) begin
         rx_busy = 1;
         rx_dly = $urandom_range(dly_hi, 0);
      end

      from_list = push_q.size() != 0;
      if (from_list) begin
         bus.tx_valid = 1'b1;
         bus.tx_byte = push_q[0];
      end else begin
         bus.tx_valid = $urandom_range(99, 0) < push_pct;
         bus.tx_byte = 8'($urandom);
      end
      bus.rx_ready = pop_one || ($urandom_range(99, 0) < pop_pct);
      pop_one = 0;
      bus.rx_want = want;

      bus.tx_done = 1'b0;
      if (tx_busy && !tp) begin
         if (!hold_tx) begin
            if (tx_dly == 0) bus.tx_done = 1'b1;
            else tx_dly--;
         end
      end else if (!tx_busy && spur) begin
         bus.tx_done = $urandom_range(7, 0) == 0;
      end

      bus.rx_done = 1'b0;
      if (rx_busy && !rp) begin
         if (!hold_rx) begin
            if (rx_dly == 0) bus.rx_done = 1'b1;
            else rx_dly--;
         end
      end else if (!rx_busy && spur) begin
         bus.rx_done = $urandom_range(7, 0) == 0;
      end
      bus.r_data = rdata_fix ? rdata_val : 8'($urandom);

      rstn = !rst_req;
      rst_req = 0;

      if (!rstn) begin
         model_reset();
      end else begin
         idle = !tx_busy && !rx_busy;
         exp_tv = idle && txq.size() != 0;
         exp_rv = idle && txq.size() == 0 && bus.rx_want &&
                  rxq.size() < DEPTH;
         acc  = bus.tx_valid && txq.size() < DEPTH;
         pop  = bus.rx_ready && rxq.size() != 0;
         tfin = bus.tx_done && tx_busy && !tp;
         rfin = bus.rx_done && rx_busy && !rp;
         if (acc) begin
            txq.push_back(bus.tx_byte);
            n_acc++;
            if (from_list) void'(push_q.pop_front());
         end
         if (tfin) begin
            void'(txq.pop_front());
            tx_busy = 0;
            m_txc++;
         end
         if (pop) void'(rxq.pop_front());
         if (rfin) begin
            rxq.push_back(bus.r_data);
            rx_busy = 0;
            m_rxc++;
         end
      end
   endtask

   initial begin
      int push_cyc, tv0, rv0, acc0, n, t_first, r_first;
      rstn = 1'b0;
      bus.tx_valid = 0; bus.tx_byte = 0; bus.rx_ready = 0;
      bus.rx_want = 0; bus.r_data = 0; bus.tx_done = 0; bus.rx_done = 0;
      push_pct = 0; pop_pct = 0; dly_hi = 0; want = 0;
      hold_tx = 0; hold_rx = 0; spur = 0; pop_one = 0; rst_req = 0;
      rdata_fix = 0; rdata_val = 0;
      cyc = 0; tv_cnt = 0; rv_cnt = 0; tv_cyc = 0; n_acc = 0;
      model_reset();
      repeat (3) @(negedge clk);

      // single byte, driver stalled
      hold_tx = 1;
      push_q.push_back(8'h41);
      step();
      push_cyc = cyc;
      tv0 = tv_cnt;
      repeat (22) step();
      check("s1_pulses", 32'(tv_cnt - tv0), 32'd1);
      check("s1_latency", 32'(tv_cyc - push_cyc), 32'd2);
      check("s1_hold", 32'(bus.t_data), 32'h41);
      hold_tx = 0;
      repeat (6) step();
      check("s1_no_repeat", 32'(tv_cnt - tv0), 32'd1);

      // overfill TX with driver stalled
      rst_req = 1;
      step();
      hold_tx = 1;
      for (int i = 0; i < 17; i++) push_q.push_back(8'(8'h80 + i));
      tv0 = tv_cnt;
      acc0 = n_acc;
      repeat (25) step();
      check("s2_ready_low", 32'(bus.tx_ready), 32'd0);
      check("s2_accepted", 32'(n_acc - acc0), 32'd16);
      check("s2_one_req", 32'(tv_cnt - tv0), 32'd1);
      hold_tx = 0;
      dly_hi = 3;
      n = 0;
      while ((push_q.size() != 0 || txq.size() != 0) && n < 500) begin
         step();
         n++;
      end
      check("s2_drain_timeout", 32'(n < 500), 32'd1);
      step();
      check("s2_reqs", 32'(tv_cnt - tv0), 32'd17);
`ifdef UART_BUF_STATS_EN
      check("s2_tx_count", bus.tx_count, 32'd17);
`else
      check("s2_tx_count", bus.tx_count, 32'd0);
`endif

      // single RX byte
      want = 1;
      hold_rx = 1;
      rv0 = rv_cnt;
      repeat (10) step();
      check("s3_one_req", 32'(rv_cnt - rv0), 32'd1);
      want = 0;
      hold_rx = 0;
      dly_hi = 0;
      rdata_fix = 1;
      rdata_val = 8'h5A;
      n = 0;
      while (rxq.size() == 0 && n < 50) begin
         step();
         n++;
      end
      check("s3_rx_timeout", 32'(n < 50), 32'd1);
      step();
      check("s3_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("s3_rx_byte", 32'(bus.rx_byte), 32'h5A);
      pop_one = 1;
      step();
      step();
      check("s3_popped", 32'(bus.rx_valid), 32'd0);
      rdata_fix = 0;

      // TX priority over RX
      pop_pct = 100;
      push_q.push_back(8'h11);
      step();
      want = 1;
      tv0 = tv_cnt;
      rv0 = rv_cnt;
      t_first = 0;
      r_first = 0;
      repeat (12) begin
         step();
         if (t_first == 0 && tv_cnt != tv0) t_first = cyc;
         if (r_first == 0 && rv_cnt != rv0) r_first = cyc;
      end
      check("s4_tx_first", 32'(t_first > 0 && t_first < r_first), 32'd1);
      hold_rx = 1;
      n = 0;
      while (!rx_busy && n < 50) begin
         step();
         n++;
      end
      check("s4_rx_busy_timeout", 32'(n < 50), 32'd1);
      push_q.push_back(8'h22);
      tv0 = tv_cnt;
      repeat (10) step();
      check("s4_tx_blocked", 32'(tv_cnt - tv0), 32'd0);
      hold_rx = 0;
      want = 0;
      repeat (10) step();
      check("s4_tx_after", 32'(tv_cnt - tv0), 32'd1);

      // fill RX FIFO
      repeat (10) step();
      pop_pct = 0;
      want = 1;
      dly_hi = 1;
      n = 0;
      while (rxq.size() < DEPTH && n < 400) begin
         step();
         n++;
      end
      check("s5_fill_timeout", 32'(n < 400), 32'd1);
      rv0 = rv_cnt;
      repeat (20) step();
      check("s5_no_req", 32'(rv_cnt - rv0), 32'd0);
      check("s5_full_valid", 32'(bus.rx_valid), 32'd1);
      pop_one = 1;
      step();
      repeat (20) step();
      check("s5_one_more", 32'(rv_cnt - rv0), 32'd1);

      // reset during TX_WAIT
      want = 0;
      hold_tx = 1;
      for (int i = 0; i < 3; i++) push_q.push_back(8'(8'hC0 + i));
      n = 0;
      while ((push_q.size() != 0 || !tx_busy) && n < 50) begin
         step();
         n++;
      end
      check("s6_busy_timeout", 32'(n < 50), 32'd1);
      repeat (3) step();
      rst_req = 1;
      step();
      step();
      check("s6_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("s6_t_valid", 32'(bus.t_valid), 32'd0);
      check("s6_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("s6_tx_count", bus.tx_count, 32'd0);
      check("s6_rx_count", bus.rx_count, 32'd0);
      hold_tx = 0;

      // randomised traffic
      spur = 1;
      for (int blk = 0; blk < 20; blk++) begin
         push_pct = $urandom_range(90, 0);
         pop_pct = $urandom_range(100, 0);
         want = $urandom_range(1, 0) == 1;
         dly_hi = $urandom_range(6, 0);
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(999, 0) == 0) rst_req = 1;
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
